ltm_video_out: RTL and testbench
================================

// Module: ltm_video_out
// PURPOSE
//  Parametrised successor to the fixed-timing LTM video output. Takes a pixel stream
//  (valid/ready, start-of-packet marks pixel 0 of a frame) and buffers it in a FIFO.
//  Generates programmable H/V timing and drives the panel video bus.
//  Locks stream to raster, flags underflow, resynchronises on the next frame.
//  Sits between the raytracer frame reader and the LTM panel pins.
// PARAMETERS
//  DATA_W      24   pixel width (RGB888)
//  FIFO_DEPTH  16   pixel FIFO entries, power of 2, >=4
//  CLK_DIV     1    pixel tick every CLK_DIV clocks (1..16)
//  H_ACTIVE    800  H_FP 40  H_SYNC 128  H_BP 88   horizontal timing, in pixels
//  V_ACTIVE    480  V_FP 1   V_SYNC 3    V_BP 21   vertical timing, in lines
//  HS_POL      0    V_POL 0   sync active level
// PORTS
//  clk_clk        in   1       single clock; all logic on rising edge
//  reset_reset    in   1       synchronous, active-high reset
//  snk_data       in   DATA_W  pixel
//  snk_sop        in   1       first pixel of frame
//  snk_valid      in   1       pixel valid
//  snk_ready      out  1       FIFO accepts (= !full)
//  vid_data       out  DATA_W  pixel to panel
//  vid_datavalid  out  1       active region
//  vid_h_sync     out  1       HSYNC (HS_POL level)
//  vid_v_sync     out  1       VSYNC (V_POL level)
//  vid_h          out  1       horizontal blanking
//  vid_v          out  1       vertical blanking
//  vid_f          out  1       field, constant 0 (progressive)
//  underflow      out  1       sticky underflow/sync-loss flag
// BEHAVIOUR
//  - Reset: all counters 0. State SYNC_WAIT. FIFO emptied.
//    vid_data=0, vid_datavalid=0, vid_h=vid_v=1. Syncs at inactive level.
//    underflow=0, snk_ready=0 during reset and 1 the cycle after.
//  - Tick: prescaler 0..CLK_DIV-1; tick when it is 0. h_cnt 0..H_TOTAL-1, wraps to 0 and
//    increments v_cnt (wraps at V_TOTAL). Segment order per axis: active, FP, SYNC, BP.
//  - Outputs are registered: they update on a tick cycle from that tick's counters.
//    Outputs are held between ticks.
//  - FIFO word = {sop,data}. Push when snk_valid&&snk_ready. Push and pop in the same
//    cycle are both legal; occupancy is unchanged.
//  - SYNC_WAIT:
//    - Pop and discard head words with sop=0.
//    - With sop=1 at head, wait for the tick at h=0,v=0. Enter RUN and present that pixel.
//    - Outputs blank: vid_data=0 while active.
//  - RUN: pop one word each active tick and present it.
//    - FIFO empty at an active tick: vid_data=0, underflow<=1, go SYNC_WAIT.
//    - sop=1 at head at an active tick other than (0,0): do not pop; underflow<=1,
//      go SYNC_WAIT.
//  - underflow clears only on entry to RUN. Timing outputs never stall in any state.
//  - Reset mid-frame: immediate return to reset state on the next edge.
// CONFIGURATION
//  LTM_TESTPATTERN_EN defined:
//  - Adds input tp_sel (1 bit).
//  - While tp_sel=1, active pixels are 8 vertical colour bars, each H_ACTIVE/8 wide.
//    Order: white, yellow, cyan, green, magenta, red, blue, black.
//  - While tp_sel=1: FIFO is drained (snk_ready=1, words discarded), state forced
//    SYNC_WAIT, underflow held 0.
//  Not defined: no tp_sel port, no pattern logic.
// STRUCTURE
//  Package ltm_video_pkg holds:
//  - state enum {SYNC_WAIT, RUN}
//  - H_TOTAL/V_TOTAL computation function
//  - 8-entry colour bar constant table
//  Sub-module ltm_pix_fifo: synchronous FIFO, width DATA_W+1, depth FIFO_DEPTH.
//  - Ports: push, pop, full, empty, head data; first-word-fall-through.
// TESTING
//  Bench timing: H 8/2/2/2 (H_TOTAL=14), V 4/1/1/1 (V_TOTAL=7), CLK_DIV=1, DEPTH=8.
//  1. Reset, then feed frames with pixel value = index and sop on 0.
//     -> first datavalid at frame start shows 0x000000, then 1..31.
//     -> vid_h_sync low at h=10,11; vid_v_sync low for line 5; underflow=0.
//  2. Feed 3 junk words (sop=0) before the first sop.
//     -> junk is discarded; the displayed frame begins with the sop pixel.
//  3. Stop feeding at pixel 12 of the frame.
//     -> pixel 12 outputs 0 and underflow=1 from that cycle.
//     -> next frame is displayed normally; underflow clears at its (0,0).
//  4. Insert an early sop at pixel 20 of the stream.
//     -> underflow=1, resync; the sop frame is shown from the next (0,0).
//  5. CLK_DIV=3 -> each output is held 3 clocks; the frame lasts 3*14*7=294 clocks.
//  6. Build with LTM_TESTPATTERN_EN, tp_sel=1 -> row pixels read FFFFFF and FFFF00,
//     one pixel each (H_ACTIVE/8=1).
//     -> snk_ready stays 1 throughout and underflow stays 0.

Source files
------------

// File: rtl/ltm_video_pkg.sv
// ltm_video_pkg: shared state encoding, raster total helper and colour-bar table for ltm_video_out
package ltm_video_pkg;
  typedef enum logic {SYNC_WAIT, RUN} state_t;
  localparam logic [23:0] BARS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };
  function automatic int total(input int a, input int b, input int c, input int d);
    return a + b + c + d;
  endfunction
endpackage

// File: rtl/ltm_pix_fifo.sv
// ltm_pix_fifo: first-word-fall-through synchronous FIFO holding {sop,pixel} words
module ltm_pix_fifo #(
  parameter int W = 25,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign empty = wp == rp;
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) begin
        mem[wp[AW-1:0]] <= din;
        wp <= wp + (AW+1)'(1);
      end
      if (pop && !empty) rp <= rp + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/ltm_video_out.sv
// ltm_video_out: FIFO-buffered pixel stream locked to programmable raster timing; LTM_TESTPATTERN_EN adds tp_sel colour bars
module ltm_video_out
  import ltm_video_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_DIV = 1,
  parameter int H_ACTIVE = 800,
  parameter int H_FP = 40,
  parameter int H_SYNC = 128,
  parameter int H_BP = 88,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 1,
  parameter int V_SYNC = 3,
  parameter int V_BP = 21,
  parameter bit HS_POL = 1'b0,
  parameter bit V_POL = 1'b0
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [DATA_W-1:0] snk_data,
  input  logic              snk_sop,
  input  logic              snk_valid,
  output logic              snk_ready,
`ifdef LTM_TESTPATTERN_EN
  input  logic              tp_sel,
`endif
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_datavalid,
  output logic              vid_h_sync,
  output logic              vid_v_sync,
  output logic              vid_h,
  output logic              vid_v,
  output logic              vid_f,
  output logic              underflow
);
  localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [HW-1:0] H_A = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_S0 = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_S1 = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [HW-1:0] H_L = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_A = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_S0 = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_S1 = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [VW-1:0] V_L = VW'(V_TOTAL - 1);
  state_t state, state_n;
  logic [PW-1:0] pre;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [DATA_W:0] head;
  logic [DATA_W-1:0] head_data, data_n;
  logic head_sop, full, empty, push, pop, uf_n;
  logic tick, h_act, v_act, act, origin, in_hs, in_vs;
  assign tick = pre == '0;
  assign h_act = h < H_A;
  assign v_act = v < V_A;
  assign act = h_act && v_act;
  assign origin = h == '0 && v == '0;
  assign in_hs = h >= H_S0 && h <= H_S1;
  assign in_vs = v >= V_S0 && v <= V_S1;
  assign head_sop = head[DATA_W];
  assign head_data = head[DATA_W-1:0];
  assign vid_f = 1'b0;
`ifdef LTM_TESTPATTERN_EN
  localparam int BW = H_ACTIVE / 8 > 0 ? H_ACTIVE / 8 : 1;
  logic [2:0] bar;
  assign bar = (int'(h) / BW > 7) ? 3'd7 : 3'(int'(h) / BW);
  assign snk_ready = !reset_reset && (tp_sel || !full);
  assign push = snk_valid && snk_ready && !tp_sel;
`else
  assign snk_ready = !reset_reset && !full;
  assign push = snk_valid && snk_ready;
`endif
  ltm_pix_fifo #(.W(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_clk),
    .rst(reset_reset),
    .push(push),
    .pop(pop),
    .din({snk_sop, snk_data}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    state_n = state;
    pop = 1'b0;
    data_n = '0;
    uf_n = underflow;
    if (state == SYNC_WAIT) begin
      pop = !empty && !head_sop;
      if (tick && origin && !empty && head_sop) begin
        pop = 1'b1;
        state_n = RUN;
        data_n = head_data;
        uf_n = 1'b0;
      end
    end else if (tick && act) begin
      if (empty || (head_sop && !origin)) begin
        uf_n = 1'b1;
        state_n = SYNC_WAIT;
      end else begin
        pop = 1'b1;
        data_n = head_data;
      end
    end
`ifdef LTM_TESTPATTERN_EN
    if (tp_sel) begin
      pop = !empty;
      state_n = SYNC_WAIT;
      uf_n = 1'b0;
      data_n = act ? DATA_W'(BARS[bar]) : '0;
    end
`endif
  end
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      pre <= '0;
      h <= '0;
      v <= '0;
      state <= SYNC_WAIT;
      underflow <= 1'b0;
      vid_data <= '0;
      vid_datavalid <= 1'b0;
      vid_h_sync <= !HS_POL;
      vid_v_sync <= !V_POL;
      vid_h <= 1'b1;
      vid_v <= 1'b1;
    end else begin
      pre <= (pre == PW'(CLK_DIV - 1)) ? '0 : pre + PW'(1);
      state <= state_n;
      underflow <= uf_n;
      if (tick) begin
        h <= (h == H_L) ? '0 : h + HW'(1);
        v <= (h != H_L) ? v : (v == V_L) ? '0 : v + VW'(1);
        vid_data <= data_n;
        vid_datavalid <= act;
        vid_h_sync <= in_hs ? HS_POL : !HS_POL;
        vid_v_sync <= in_vs ? V_POL : !V_POL;
        vid_h <= !h_act;
        vid_v <= !v_act;
      end
    end
  end
endmodule

// File: tb/tb_ltm_video_out.sv
// tb_ltm_video_out: scoreboard bench for ltm_video_out on a 14x7 raster, plus a CLK_DIV=3 instance
module tb_ltm_video_out;
  typedef struct {
    logic [23:0] d;
    logic u;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [23:0] snk_data = '0;
  logic snk_sop = 1'b0, snk_valid = 1'b0;
  logic snk_ready, vid_datavalid, vid_h_sync, vid_v_sync, vid_h, vid_v, vid_f, underflow;
  logic [23:0] vid_data;
  logic [23:0] d2_data;
  logic d2_rdy, d2_dv, d2_hs, d2_vs, d2_h, d2_v, d2_f, d2_uf;
  int total = 0, bad = 0;
  bit run1 = 1'b0, done = 1'b0;
  exp_t exp_q[$];
  logic [24:0] in_q[$];
  always #5 clk = ~clk;
  ltm_video_out #(
    .DATA_W(24), .FIFO_DEPTH(8), .CLK_DIV(1),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .V_POL(1'b0)
  ) dut (
    .clk_clk(clk), .reset_reset(rst),
    .snk_data(snk_data), .snk_sop(snk_sop), .snk_valid(snk_valid), .snk_ready(snk_ready),
`ifdef LTM_TESTPATTERN_EN
    .tp_sel(1'b0),
`endif
    .vid_data(vid_data), .vid_datavalid(vid_datavalid), .vid_h_sync(vid_h_sync),
    .vid_v_sync(vid_v_sync), .vid_h(vid_h), .vid_v(vid_v), .vid_f(vid_f), .underflow(underflow)
  );
  ltm_video_out #(
    .DATA_W(24), .FIFO_DEPTH(8), .CLK_DIV(3),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .V_POL(1'b0)
  ) dut2 (
    .clk_clk(clk), .reset_reset(rst),
    .snk_data(24'h123456), .snk_sop(1'b0),
`ifdef LTM_TESTPATTERN_EN
    .snk_valid(1'b1), .snk_ready(d2_rdy), .tp_sel(1'b1),
`else
    .snk_valid(1'b0), .snk_ready(d2_rdy),
`endif
    .vid_data(d2_data), .vid_datavalid(d2_dv), .vid_h_sync(d2_hs),
    .vid_v_sync(d2_vs), .vid_h(d2_h), .vid_v(d2_v), .vid_f(d2_f), .underflow(d2_uf)
  );
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic exp_frame(input int base, input int n, input logic uf);
    for (int i = 0; i < 32; i++) begin
      exp_t e;
      e.d = i < n ? 24'(base + i) : 24'h0;
      e.u = i < n ? 1'b0 : uf;
      exp_q.push_back(e);
    end
  endtask
  task automatic feed(input int base, input int n);
    for (int i = 0; i < n; i++) in_q.push_back({i == 0, 24'(base + i)});
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (in_q.size() > 0) begin
        snk_valid = 1'b1;
        {snk_sop, snk_data} = in_q[0];
        if (snk_ready) void'(in_q.pop_front());
      end else begin
        snk_valid = 1'b0;
      end
    end
  end
  initial begin
    int hm = 0, vm = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (run1) begin
        chk("hsync", vid_h_sync, !(hm == 10 || hm == 11));
        chk("vsync", vid_v_sync, !(vm == 5));
        chk("datavalid", vid_datavalid, hm < 8 && vm < 4);
        chk("hblank", vid_h, !(hm < 8));
        chk("vblank", vid_v, !(vm < 4));
        chk("field", vid_f, 0);
        if (vid_datavalid && !done) begin
          if (exp_q.size() == 0) begin
            chk("extra_pixel", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("pixel", vid_data, e.d);
            chk("underflow", underflow, e.u);
          end
        end
        if (hm == 13) begin
          hm = 0;
          vm = vm == 6 ? 0 : vm + 1;
        end else begin
          hm++;
        end
      end
    end
  end
  initial begin
    int vs_cnt = 0, hs_run = 0, dv_run = 0, p;
    bit have_vs = 1'b0;
    logic pvs = 1'b1, phs = 1'b1, pdv = 1'b0;
    forever begin
      @(negedge clk);
      if (run1) begin
        vs_cnt++;
        if (pvs && !d2_vs) begin
          if (have_vs) chk("div3_frame_len", vs_cnt, 294);
          have_vs = 1'b1;
          vs_cnt = 0;
        end
        if (!d2_hs) hs_run++;
        else if (!phs) begin
          chk("div3_hsync_len", hs_run, 6);
          hs_run = 0;
        end
        if (d2_dv) begin
          dv_run++;
          p = (dv_run - 1) / 3;
`ifdef LTM_TESTPATTERN_EN
          if (p < 2) chk("tp_bar", d2_data, p == 0 ? 'hFFFFFF : 'hFFFF00);
`else
          chk("div3_blank_data", d2_data, 0);
`endif
        end else if (pdv) begin
          chk("div3_active_len", dv_run, 24);
          dv_run = 0;
        end
        chk("div3_blank_flags", d2_dv, !d2_h && !d2_v);
        chk("div3_field", d2_f, 0);
        chk("div3_ready", d2_rdy, 1);
        chk("div3_underflow", d2_uf, 0);
        pvs = d2_vs;
        phs = d2_hs;
        pdv = d2_dv;
      end
    end
  end
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_data", vid_data, 0);
    chk("rst_datavalid", vid_datavalid, 0);
    chk("rst_hblank", vid_h, 1);
    chk("rst_vblank", vid_v, 1);
    chk("rst_hsync", vid_h_sync, 1);
    chk("rst_vsync", vid_v_sync, 1);
    chk("rst_underflow", underflow, 0);
    chk("rst_ready", snk_ready, 0);
    rst = 1'b0;
    @(posedge clk);
    run1 = 1'b1;
    exp_frame(0, 0, 1'b0);
    for (int i = 0; i < 3; i++) in_q.push_back({1'b0, 24'(24'hAA0000 + i)});
    feed(0, 32);
    exp_frame(0, 32, 1'b0);
    feed('h200, 12);
    exp_frame('h200, 12, 1'b1);
    @(negedge clk);
    chk("ready_after_rst", snk_ready, 1);
    n = 0;
    while (!underflow && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("underflow_rise", underflow, 1);
    feed('h300, 32);
    exp_frame('h300, 32, 1'b0);
    feed('h400, 20);
    exp_frame('h400, 20, 1'b1);
    feed('h500, 32);
    exp_frame('h500, 32, 1'b0);
    exp_frame(0, 0, 1'b1);
    n = 0;
    while (exp_q.size() > 0 && n < 1500) begin
      @(posedge clk);
      n++;
    end
    done = 1'b1;
    chk("scoreboard_drained", exp_q.size(), 0);
    repeat (20) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
